// File: rtl/kyber_ctrl_pkg.sv
// Shared definitions for the Kyber run-control sequencer: state encoding,
// default timing constants and small state-class helpers.
package kyber_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] RESET_HOLD = 3'd1;
  localparam logic [STATE_W-1:0] SETTLE     = 3'd2;
  localparam logic [STATE_W-1:0] START      = 3'd3;
  localparam logic [STATE_W-1:0] RUN        = 3'd4;
  localparam logic [STATE_W-1:0] DONE       = 3'd5;
  localparam logic [STATE_W-1:0] TIMEOUT    = 3'd6;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TIMEOUT_CYC = 1000000;
  localparam int DEF_SETTLE_CYC  = 4;

  // States in which a start edge may launch a new run.
  function automatic logic is_ready(input logic [STATE_W-1:0] s);
    return (s == IDLE) || (s == DONE) || (s == TIMEOUT);
  endfunction

  function automatic logic is_busy(input logic [STATE_W-1:0] s);
    return (s == RESET_HOLD) || (s == SETTLE) || (s == START) || (s == RUN);
  endfunction

endpackage

// File: rtl/kyber_rise_det.sv
// Registered rising-edge detector; PREV_RST sets the history value after
// reset so a level already high at reset can be ignored.
module kyber_rise_det #(
  parameter logic PREV_RST = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= PREV_RST;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/kyber_run_ctrl.sv
// Kyber core run-control: sequences core reset/settle, launches runs,
// measures run length, aborts hung runs and keeps sticky status.
//
// state      | meaning
// IDLE       | ready, waiting for a start edge
// RESET_HOLD | core held in reset while rst_pulse is high
// SETTLE     | core reset released, waiting SETTLE_CYC cycles
// START      | one-cycle start strobe to the core
// RUN        | core running, counting cycles toward timeout
// DONE       | last run completed; ready
// TIMEOUT    | last run aborted by timeout; ready
module kyber_run_ctrl
  import kyber_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_pulse,
  input  logic             start_in,
  input  logic             core_done,
  output logic             core_rst,
  output logic             core_start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             start_ovr,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] TC_VAL      = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_cycles;
  logic               r_done;
  logic               r_timeout;
  logic               r_start_ovr;

  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cycles_nxt;
  logic               w_done_nxt;
  logic               w_timeout_nxt;
  logic               w_start_ovr_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_start_edge;

  // History resets high so a start level held through reset is not an edge.
  kyber_rise_det #(
    .PREV_RST (1'b1)
  ) u_start_det (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_d    (start_in),
    .o_rise (w_start_edge)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cycles_nxt    = r_cycles;
    w_done_nxt      = r_done;
    w_timeout_nxt   = r_timeout;
    w_start_ovr_nxt = r_start_ovr;

    if (rst_pulse) begin
      w_state_nxt     = RESET_HOLD;
      w_cnt_nxt       = '0;
      w_done_nxt      = 1'b0;
      w_timeout_nxt   = 1'b0;
      w_start_ovr_nxt = 1'b0;
    end else begin
      case (r_state)
        RESET_HOLD: begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end
        SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        IDLE, DONE, TIMEOUT: begin
          if (w_start_edge) begin
            w_state_nxt = START;
          end
        end
        START: begin
          w_state_nxt   = RUN;
          w_cnt_nxt     = '0;
          w_done_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
          if (w_start_edge) begin
            w_start_ovr_nxt = 1'b1;
          end
        end
        RUN: begin
          w_cnt_nxt = w_cnt_inc;
          if (w_start_edge) begin
            w_start_ovr_nxt = 1'b1;
          end
          // Completion on the terminal-count cycle still counts as a success.
          if (core_done) begin
            w_state_nxt  = DONE;
            w_cycles_nxt = w_cnt_inc;
            w_done_nxt   = 1'b1;
          end else if (w_cnt_inc == TC_VAL) begin
            w_state_nxt   = TIMEOUT;
            w_cycles_nxt  = TC_VAL;
            w_timeout_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cycles    <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_start_ovr <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cycles    <= w_cycles_nxt;
      r_done      <= w_done_nxt;
      r_timeout   <= w_timeout_nxt;
      r_start_ovr <= w_start_ovr_nxt;
    end
  end

  assign core_rst   = (r_state == RESET_HOLD);
  assign core_start = (r_state == START);
  assign busy       = is_busy(r_state);
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign start_ovr  = r_start_ovr;
  assign cycles     = r_cycles;

endmodule

// File: tb/tb_kyber_run_ctrl.sv
// Scoreboard bench for kyber_run_ctrl: runs are described as transactions
// (completion cycle or none), expected results queued, and a monitor pops
// and compares when the controller leaves a run.
module tb_kyber_run_ctrl;

  localparam int CNT_W = 32;
  localparam int TO    = 8;
  localparam int SC    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             rst_pulse;
  logic             start_in;
  logic             core_done;
  logic             core_rst;
  logic             core_start;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             start_ovr;
  logic [CNT_W-1:0] cycles;

  always #5 clk = ~clk;

  kyber_run_ctrl #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TO),
    .SETTLE_CYC  (SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rst_pulse  (rst_pulse),
    .start_in   (start_in),
    .core_done  (core_done),
    .core_rst   (core_rst),
    .core_start (core_start),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .start_ovr  (start_ovr),
    .cycles     (cycles)
  );

  typedef struct packed {
    logic        d;
    logic        t;
    logic        o;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          start_cnt = 0;
  int          pushed = 0;
  int          popped = 0;
  logic        prev_busy = 1'b0;
  logic        exp_ovr = 1'b0;
  logic [31:0] prev_cycles = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, expv);
    end
  endtask

  // Monitor: a run has finished when busy falls with a result flag set.
  always @(negedge clk) begin
    if (core_start === 1'b1) start_cnt++;
    if (prev_busy && !busy && (done || timeout)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty actual=result(done=%0d timeout=%0d) required=none", done, timeout);
      end else begin
        mon_e = sb.pop_front();
        popped++;
        chk("res_done", done, mon_e.d);
        chk("res_timeout", timeout, mon_e.t);
        chk("res_start_ovr", start_ovr, mon_e.o);
        chk("res_cycles", cycles, mon_e.cyc);
      end
    end
    prev_busy = busy;
  end

  // rst_pulse high for 10 cycles; core_rst must follow one clock late for
  // exactly 10 cycles, then SETTLE_CYC cycles of busy before idle.
  task automatic reset_seq(input bit settle_edge);
    for (int k = 0; k < 17; k++) begin
      rst_pulse = (k < 10);
      if (settle_edge && k == 2)  start_in = 1'b0;
      if (settle_edge && k == 11) start_in = 1'b1;
      @(negedge clk);
      chk($sformatf("rseq_core_rst_%0d", k), core_rst, (k <= 9));
      chk($sformatf("rseq_busy_%0d", k), busy, (k <= 9 + SC));
      chk($sformatf("rseq_core_start_%0d", k), core_start, 1'b0);
    end
    chk("rseq_start_ovr", start_ovr, 1'b0);
    exp_ovr = 1'b0;
  endtask

  // done_at: RUN cycle (1-based) carrying core_done, 0 = never.
  // ovr: extra start edge sampled at the end of RUN cycle 2.
  // abort_at: RUN cycle on which rst_pulse is raised, 0 = none.
  task automatic do_run(input int done_at, input bit ovr_in, input int abort_at);
    int   n0;
    int   r;
    bit   seen;
    bit   ovr;
    exp_t e;
    ovr  = ovr_in && (done_at == 0 || done_at >= 2);
    n0   = start_cnt;
    start_in = 1'b0;
    @(negedge clk);
    start_in = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      if (core_start) seen = 1'b1;
    end
    chk("start_seen", seen, 1'b1);
    if (!seen) return;
    exp_ovr = exp_ovr | ovr;
    if (abort_at == 0) begin
      e.d   = (done_at >= 1 && done_at <= TO);
      e.t   = !(done_at >= 1 && done_at <= TO);
      e.o   = exp_ovr;
      e.cyc = e.d ? 32'(done_at) : 32'(TO);
      sb.push_back(e);
      pushed++;
    end
    @(negedge clk);
    r = 1;
    while (r <= TO + 2) begin
      core_done = (r == done_at);
      if (ovr && r == 1) start_in = 1'b0;
      if (ovr && r == 2) start_in = 1'b1;
      if (r == 1) begin
        chk("run1_busy", busy, 1'b1);
        chk("run1_done_clr", done, 1'b0);
        chk("run1_timeout_clr", timeout, 1'b0);
        chk("run1_cycles_hold", cycles, prev_cycles);
      end
      if (r == abort_at) begin
        chk("pre_abort_ovr", start_ovr, exp_ovr);
        rst_pulse = 1'b1;
        core_done = 1'b0;
        break;
      end
      @(negedge clk);
      if (!busy) break;
      r++;
    end
    core_done = 1'b0;
    chk("one_core_start", start_cnt - n0, 1);
    if (abort_at != 0) begin
      @(negedge clk);
      chk("abort_core_rst", core_rst, 1'b1);
      chk("abort_done", done, 1'b0);
      chk("abort_timeout", timeout, 1'b0);
      chk("abort_start_ovr", start_ovr, 1'b0);
      chk("abort_cycles", cycles, prev_cycles);
      exp_ovr = 1'b0;
      repeat (3) @(negedge clk);
      rst_pulse = 1'b0;
      for (int k = 0; k < 20 && busy; k++) @(negedge clk);
      chk("abort_recovered", busy, 1'b0);
    end else begin
      chk("run_ended", busy, 1'b0);
      prev_cycles = e.cyc;
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int da;
    rst       = 1'b1;
    rst_pulse = 1'b0;
    start_in  = 1'b1;
    core_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("por_core_start", core_start, 1'b0);
      chk("por_busy", busy, 1'b0);
      chk("por_core_rst", core_rst, 1'b0);
    end
    chk("por_done", done, 1'b0);
    chk("por_timeout", timeout, 1'b0);
    chk("por_start_ovr", start_ovr, 1'b0);
    chk("por_cycles", cycles, 32'd0);

    reset_seq(1'b1);

    do_run(3, 1'b0, 0);
    do_run(0, 1'b0, 0);
    do_run(TO, 1'b0, 0);
    do_run(4, 1'b1, 0);
    do_run(0, 1'b1, 5);

    for (int i = 0; i < 12; i++) begin
      da = $urandom_range(0, TO + 1);
      do_run(da, 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("results_seen", popped, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
